// File: rtl/light_countdown_display_pkg.sv
// Shared constants for the light countdown display: phase times, one-hot light codes,
// and the 7-segment digit table.
package light_countdown_display_pkg;

  localparam int TIME_GREEN_DEF  = 15;
  localparam int TIME_YELLOW_DEF = 3;
  localparam int TIME_RED_DEF    = 18;

  typedef enum logic [2:0] {
    LIGHT_NONE   = 3'b000,
    LIGHT_GREEN  = 3'b001,
    LIGHT_YELLOW = 3'b010,
    LIGHT_RED    = 3'b100
  } light_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/light_countdown_display_seg7_digit_decoder.sv
// Combinational BCD digit to 7-segment {g..a}, active-high; non-BCD codes blank.
module seg7_digit_decoder
  import light_countdown_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit < 4'd10) seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/light_countdown_display.sv
// Countdown of seconds left in the current light phase, shown on two 7-seg digits.
// Optional COUNTDOWN_BLINK_EN: blink the digits during the last few seconds.
module light_countdown_display
  import light_countdown_display_pkg::*;
#(
  parameter int pTIME_GREEN_LIGHT  = TIME_GREEN_DEF,
  parameter int pTIME_YELLOW_LIGHT = TIME_YELLOW_DEF,
  parameter int pTIME_RED_LIGHT    = TIME_RED_DEF,
  parameter int pCNT_WIDTH         = 7
`ifdef COUNTDOWN_BLINK_EN
  , parameter int pBLINK_THRESH    = 3
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sec_tick,
  input  logic                  green_light,
  input  logic                  yellow_light,
  input  logic                  red_light,
  output logic [pCNT_WIDTH-1:0] remain,
  output logic [6:0]            seg_a,
  output logic [6:0]            seg_b,
  output logic                  phase_err
);

  logic [2:0]            light;
  logic [2:0]            prev_light;
  logic                  valid;
  logic                  load;
  logic                  blank;
  logic [pCNT_WIDTH-1:0] load_val;
  logic [3:0]            tens;
  logic [3:0]            units;
  logic [6:0]            dec_a;
  logic [6:0]            dec_b;

  assign light = {red_light, yellow_light, green_light};
  assign valid = (light == LIGHT_GREEN) || (light == LIGHT_YELLOW) || (light == LIGHT_RED);
  assign load  = valid && (light != prev_light);

  always_comb begin
    load_val = '0;
    case (light)
      LIGHT_GREEN:  load_val = pCNT_WIDTH'(pTIME_GREEN_LIGHT);
      LIGHT_YELLOW: load_val = pCNT_WIDTH'(pTIME_YELLOW_LIGHT);
      LIGHT_RED:    load_val = pCNT_WIDTH'(pTIME_RED_LIGHT);
      default:      load_val = '0;
    endcase
  end

  assign tens  = 4'(remain / pCNT_WIDTH'(10));
  assign units = 4'(remain % pCNT_WIDTH'(10));

  seg7_digit_decoder u_dec_a (.digit(tens),  .seg(dec_a));
  seg7_digit_decoder u_dec_b (.digit(units), .seg(dec_b));

`ifdef COUNTDOWN_BLINK_EN
  logic blink_ph;

  // A load restarts the blink cycle so a new phase always starts visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               blink_ph <= 1'b0;
    else if (en) begin
      if (load)            blink_ph <= 1'b0;
      else if (sec_tick)   blink_ph <= ~blink_ph;
    end
  end

  assign blank = blink_ph && (remain != '0) && (remain <= pCNT_WIDTH'(pBLINK_THRESH));
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_light <= LIGHT_NONE;
      remain     <= '0;
      phase_err  <= 1'b0;
      seg_a      <= SEG_BLANK;
      seg_b      <= SEG_BLANK;
    end else if (en) begin
      prev_light <= light;
      phase_err  <= !valid;
      // Display follows the registered count/error, so it trails remain by one cycle.
      seg_a <= (phase_err || blank || remain < pCNT_WIDTH'(10)) ? SEG_BLANK : dec_a;
      seg_b <= (phase_err || blank) ? SEG_BLANK : dec_b;
      if (load)
        remain <= load_val;
      else if (valid && sec_tick && remain != '0)
        remain <= remain - 1'b1;
    end
  end

endmodule

// File: tb/tb_light_countdown_display.sv
// Randomized + directed bench for light_countdown_display against a behavioural model.
module tb_light_countdown_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sec_tick = 1'b0;
  logic       green_light = 1'b0;
  logic       yellow_light = 1'b0;
  logic       red_light = 1'b0;
  logic [6:0] remain;
  logic [6:0] seg_a;
  logic [6:0] seg_b;
  logic       phase_err;

  int total = 0;
  int bad = 0;

  light_countdown_display dut (
    .clk(clk), .rst(rst), .en(en), .sec_tick(sec_tick),
    .green_light(green_light), .yellow_light(yellow_light), .red_light(red_light),
    .remain(remain), .seg_a(seg_a), .seg_b(seg_b), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  // Model state: plain integers, phase lengths looked up by colour.
  int         m_rem;
  int         m_err;
  int         m_blink;
  logic [2:0] m_prev;
  int         m_sa;
  int         m_sb;
  int         digit7 [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int phase_len(input logic [2:0] l);
    case (l)
      3'b001:  return 15;
      3'b010:  return 3;
      3'b100:  return 18;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_rem = 0; m_err = 0; m_blink = 0; m_prev = 3'b000; m_sa = 0; m_sb = 0;
  endtask

  task automatic model_step(input bit e, input bit t, input logic [2:0] l);
    bit hide;
    if (!e) return;
    hide = (m_err != 0);
`ifdef COUNTDOWN_BLINK_EN
    if (m_blink != 0 && m_rem > 0 && m_rem <= 3) hide = 1;
`endif
    m_sa = (hide || m_rem < 10) ? 0 : digit7[m_rem / 10];
    m_sb = hide ? 0 : digit7[m_rem % 10];
    if (phase_len(l) > 0 && l != m_prev) begin
      m_rem = phase_len(l);
      m_blink = 0;
    end else begin
      if (phase_len(l) > 0 && t && m_rem > 0) m_rem = m_rem - 1;
      if (t) m_blink = 1 - m_blink;
    end
    m_err = (phase_len(l) < 0) ? 1 : 0;
    m_prev = l;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".remain"}, int'(remain), m_rem);
    chk({tag, ".err"},    int'(phase_err), m_err);
    chk({tag, ".seg_a"},  int'(seg_a), m_sa);
    chk({tag, ".seg_b"},  int'(seg_b), m_sb);
  endtask

  // One clock with the given inputs; compares #1 after the edge.
  task automatic step(input bit e, input bit t, input logic [2:0] l, input string tag);
    en = e; sec_tick = t;
    {red_light, yellow_light, green_light} = l;
    @(posedge clk);
    model_step(e, t, l);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.remain", int'(remain), 0);
    chk("rst.err",    int'(phase_err), 0);
    chk("rst.seg_a",  int'(seg_a), 0);
    chk("rst.seg_b",  int'(seg_b), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] l;
    bit e, t;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // First valid light loads green, display follows a cycle later.
    step(1, 0, 3'b001, "t1");
    chk("t1.load15", int'(remain), 15);
    step(1, 0, 3'b001, "t1d");
    chk("t1.seg_a06", int'(seg_a), 'h06);
    chk("t1.seg_b6D", int'(seg_b), 'h6D);

    // Count down through green and saturate at zero.
    for (int i = 0; i < 18; i++) step(1, 1, 3'b001, "t2");
    chk("t2.sat0", int'(remain), 0);
    step(1, 0, 3'b001, "t2d");

    // Re-enter green, tick down to 5, then change to yellow on a tick.
    step(1, 0, 3'b100, "t3r");
    step(1, 0, 3'b001, "t3g");
    for (int i = 0; i < 10; i++) step(1, 1, 3'b001, "t3");
    chk("t3.at5", int'(remain), 5);
    step(1, 1, 3'b010, "t3y");
    chk("t3.loadwins", int'(remain), 3);

    // Illegal code, then recovery to red.
    step(1, 0, 3'b011, "t4e");
    chk("t4.err", int'(phase_err), 1);
    step(1, 1, 3'b011, "t4h");
    step(1, 0, 3'b000, "t4z");
    step(1, 0, 3'b100, "t4r");
    chk("t4.red18", int'(remain), 18);
    step(1, 0, 3'b100, "t4c");

    // Freeze while the light changes underneath.
    step(1, 0, 3'b010, "t5y");
    for (int i = 0; i < 4; i++) step(0, 1, 3'b100, "t5f");
    chk("t5.frozen", int'(remain), 3);
    step(1, 0, 3'b100, "t5r");
    chk("t5.red18", int'(remain), 18);

    // Yellow countdown (blink visible only in the macro build).
    step(1, 0, 3'b010, "t6y");
    for (int i = 0; i < 5; i++) step(1, 1, 3'b010, "t6");

    // Random traffic with an async reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      e = ($urandom_range(0, 9) != 0);
      t = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 15))
        0:       l = 3'b000;
        1:       l = 3'($urandom_range(0, 7));
        2, 3:    l = 3'b001;
        4, 5:    l = 3'b010;
        6, 7:    l = 3'b100;
        default: l = m_prev;
      endcase
      step(e, t, l, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
